// File: rtl/serial_add_scheduler_if.sv
// Bundle between operand producers and serial_add_scheduler (requests, operands, grant/done, result).
// SERIAL_SCHED_SUB_EN adds per-port subtract selects op0/op1.
interface serial_add_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
`ifdef SERIAL_SCHED_SUB_EN
    logic             op0;
    logic             op1;
`endif
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             busy;

    modport master (
`ifdef SERIAL_SCHED_SUB_EN
        output op0, op1,
`endif
        output req0, a0, b0, req1, a1, b1,
        input  gnt, done, result, c_out, busy
    );

    modport slave (
`ifdef SERIAL_SCHED_SUB_EN
        input  op0, op1,
`endif
        input  req0, a0, b0, req1, a1, b1,
        output gnt, done, result, c_out, busy
    );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one LSB-first bit-serial adder between two requesters.
// Optional SERIAL_SCHED_SUB_EN: op0/op1 select subtract (A + ~B + 1) per request.
module serial_add_scheduler #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    serial_add_scheduler_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q, c_out_d;

    logic             pick;
    logic             sub_sel;
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] sum_shift;

    // Pointer only breaks ties; a lone requester always wins.
    assign pick = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

`ifdef SERIAL_SCHED_SUB_EN
    assign sub_sel = pick ? bus.op1 : bus.op0;
`else
    assign sub_sel = 1'b0;
`endif

    assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // sum_q holds the bits produced so far; the new bit enters at the top.
    assign sum_shift = {bit_sum, sum_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        result_d = result_q;
        c_out_d  = c_out_q;

        case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    owner_d      = pick;
                    a_d          = pick ? bus.a1 : bus.a0;
                    b_d          = (pick ? bus.b1 : bus.b0) ^ {WIDTH{sub_sel}};
                    carry_d      = sub_sel;
                    sum_d        = '0;
                    cnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    state_d      = StShift;
                end
            end
            StShift: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = sum_shift[WIDTH-1:1];
                carry_d = bit_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    result_d        = sum_shift;
                    c_out_d         = bit_carry;
                    done_d[owner_q] = 1'b1;
                    state_d         = StDone;
                end
            end
            StDone: begin
                ptr_d   = ~owner_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler: directed scenarios plus random traffic against an arithmetic model.
// Build with SERIAL_SCHED_SUB_EN defined to also exercise subtraction.
module tb_serial_add_scheduler;
    localparam int unsigned WIDTH   = 8;
    localparam int          Timeout = 4 * WIDTH + 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last = 1;       // last port served; ties go to the other one
    int   prev_done = 0;

    logic [WIDTH-1:0] pa[2];
    logic [WIDTH-1:0] pb[2];
    logic             psub[2];

    serial_add_scheduler_if #(.WIDTH(WIDTH)) bus ();

    serial_add_scheduler #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {carry/no-borrow, WIDTH-bit result}.
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sub);
        logic [WIDTH-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic rnd_sub();
`ifdef SERIAL_SCHED_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_req(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sub);
        pa[port]   = a;
        pb[port]   = b;
        psub[port] = sub;
        if (port == 0) begin
            bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
`ifdef SERIAL_SCHED_SUB_EN
            bus.op0 = sub;
`endif
        end else begin
            bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
`ifdef SERIAL_SCHED_SUB_EN
            bus.op1 = sub;
`endif
        end
    endtask

    task automatic drop_req(input int port);
        if (port == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
    endtask

    // Waits for the grant to port, then follows the op to completion.
    task automatic serve(input int port, input bit chk_gap, input bit fresh);
        int               waited;
        int               gcyc;
        logic [1:0]       oh;
        logic [WIDTH:0]   exp;
        oh  = 2'b01 << port;
        exp = ref_op(pa[port], pb[port], psub[port]);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.gnt == 2'b00 && waited < Timeout);
        check("gnt", bus.gnt, oh);
        if (fresh) check("gnt_lat", waited, 1);
        drop_req(port);
        gcyc = cyc;
        @(negedge clk);
        check("gnt_pulse", bus.gnt, 2'b00);
        check("busy_run", bus.busy, 1'b1);
        waited = 0;
        while (bus.done == 2'b00 && waited < Timeout) begin
            @(negedge clk);
            waited++;
        end
        check("done", bus.done, oh);
        check("done_lat", cyc - gcyc, WIDTH);
        check("result", bus.result, exp[WIDTH-1:0]);
        check("c_out", bus.c_out, exp[WIDTH]);
        if (chk_gap) check("done_gap", cyc - prev_done, WIDTH + 2);
        prev_done = cyc;
        last = port;
        @(negedge clk);
        check("done_pulse", bus.done, 2'b00);
        check("busy_idle", bus.busy, 1'b0);
        check("result_hold", {bus.c_out, bus.result}, exp);
    endtask

    task automatic apply_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_done", bus.done, 2'b00);
        check("rst_result", bus.result, '0);
        check("rst_c_out", bus.c_out, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last = 1;
    endtask

    initial begin
        int w;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
`ifdef SERIAL_SCHED_SUB_EN
        bus.op0 = 1'b0; bus.op1 = 1'b0;
`endif
        #2;
        apply_reset();

        // Single op on port 0.
        set_req(0, 8'hCD, 8'hC4, 1'b0);
        serve(0, 1'b0, 1'b1);

        // Mid-sim reset clears the held result.
        apply_reset();

        // Simultaneous requests after reset: port 0 first, port 1 one slot later.
        set_req(0, 8'h0F, 8'h01, 1'b0);
        set_req(1, 8'hFF, 8'h01, 1'b0);
        serve(0, 1'b0, 1'b1);
        serve(1, 1'b1, 1'b0);

        // Both ports keep re-requesting: strict alternation, dones WIDTH+2 apart.
        set_req(0, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
        set_req(1, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
        for (int i = 0; i < 6; i++) begin
            int p;
            p = 1 - last;
            check("rr_order", p, i % 2);
            serve(p, i > 0, i == 0);
            if (i < 4) set_req(p, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
        end

        // Reset during an op: no done, pointer back to port 0.
        set_req(1, 8'hAA, 8'h55, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.gnt == 2'b00 && w < Timeout);
        check("abort_gnt", bus.gnt, 2'b10);
        drop_req(1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_gnt0", bus.gnt, 2'b00);
        check("abort_done0", bus.done, 2'b00);
        repeat (2) begin
            @(negedge clk);
            check("abort_busy_rst", bus.busy, 1'b0);
        end
        rst = 1'b0;
        last = 1;
        repeat (WIDTH) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 2'b00);
        end
        set_req(0, 8'hAA, 8'h55, 1'b0);
        set_req(1, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
        serve(0, 1'b0, 1'b1);
        serve(1, 1'b1, 1'b0);

`ifdef SERIAL_SCHED_SUB_EN
        set_req(0, 8'h05, 8'h07, 1'b1);
        serve(0, 1'b0, 1'b1);
        set_req(0, 8'h07, 8'h05, 1'b1);
        serve(0, 1'b0, 1'b1);
`endif

        // Random traffic with random request patterns.
        for (int i = 0; i < 12; i++) begin
            int mask;
            mask = int'($urandom_range(1, 3));
            if (mask[0]) set_req(0, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
            if (mask[1]) set_req(1, WIDTH'($urandom()), WIDTH'($urandom()), rnd_sub());
            if (mask == 3) begin
                int f;
                f = 1 - last;
                serve(f, 1'b0, 1'b1);
                serve(1 - f, 1'b1, 1'b0);
            end else begin
                serve((mask == 1) ? 0 : 1, 1'b0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
